// File: rtl/register_file_if.sv
// Register file port bundle: write request, two read ports, and status.
// The master drives writes and read addresses; the register file is the slave.
interface register_file_if #(
    parameter int N = 32
);
    logic          Reg_Write_i;
    logic [31:0]   Write_Select_i;
    logic [N-1:0]  Write_Data_i;
    logic [4:0]    Read_Register_1_i;
    logic [4:0]    Read_Register_2_i;
    logic [N-1:0]  Read_Data_1_o;
    logic [N-1:0]  Read_Data_2_o;
    logic          Onehot_Error_o;
    logic [15:0]   Write_Count_o;

    modport master (
        output Reg_Write_i, Write_Select_i, Write_Data_i,
        output Read_Register_1_i, Read_Register_2_i,
        input  Read_Data_1_o, Read_Data_2_o, Onehot_Error_o, Write_Count_o
    );

    modport slave (
        input  Reg_Write_i, Write_Select_i, Write_Data_i,
        input  Read_Register_1_i, Read_Register_2_i,
        output Read_Data_1_o, Read_Data_2_o, Onehot_Error_o, Write_Count_o
    );
endinterface

// File: rtl/register_file.sv
// 32 x N register file with one-hot write select, two combinational read
// ports, optional write-to-read forwarding, a sticky malformed-select flag
// and a saturating count of committed writes. Register 0 reads as zero and
// register 29 (stack pointer) resets to SP_INIT.
module register_file #(
    parameter int           N       = 32,
    parameter logic [N-1:0] SP_INIT = N'(32'h1001_0FFC),
    parameter int           BYPASS  = 1
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave rf
);
    logic [N-1:0] regs [32];
    logic [4:0]   widx;
    logic         sel_multi;
    logic         sel_one;
    logic         commit;
    logic         onehot_err;
    logic [15:0]  wr_cnt;

    // Classify the select: clearing the lowest set bit leaves a residue only
    // when two or more bits are set. Commit is gated by reset so a write
    // pending while reset is low is neither stored nor forwarded.
    always_comb begin
        sel_multi = (rf.Write_Select_i & (rf.Write_Select_i - 32'd1)) != 32'd0;
        sel_one   = (rf.Write_Select_i != 32'd0) && !sel_multi;
        commit    = reset && rf.Reg_Write_i && sel_one && !rf.Write_Select_i[0];
    end

    // One-hot to binary index; only meaningful when sel_one is true.
    always_comb begin
        widx = '0;
        for (int k = 0; k < 32; k++) begin
            if (rf.Write_Select_i[k]) widx = widx | 5'(k);
        end
    end

    // Register array: async reset loads zeros plus SP_INIT into r29.
    // Register 0 is never written since commit excludes select bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= (k == 29) ? SP_INIT : '0;
            end
        end else if (commit) begin
            regs[widx] <= rf.Write_Data_i;
        end
    end

    // Sticky error on any multi-bit select while a write is requested.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            onehot_err <= 1'b0;
        end else if (rf.Reg_Write_i && sel_multi) begin
            onehot_err <= 1'b1;
        end
    end

    // Saturating write counter; same-data writes still count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt <= '0;
        end else if (commit && (wr_cnt != 16'hFFFF)) begin
            wr_cnt <= wr_cnt + 16'd1;
        end
    end

    // Read ports: address 0 is zero, then forwarding, then stored value.
    always_comb begin
        if (rf.Read_Register_1_i == 5'd0) begin
            rf.Read_Data_1_o = '0;
        end else if ((BYPASS != 0) && commit && (rf.Read_Register_1_i == widx)) begin
            rf.Read_Data_1_o = rf.Write_Data_i;
        end else begin
            rf.Read_Data_1_o = regs[rf.Read_Register_1_i];
        end

        if (rf.Read_Register_2_i == 5'd0) begin
            rf.Read_Data_2_o = '0;
        end else if ((BYPASS != 0) && commit && (rf.Read_Register_2_i == widx)) begin
            rf.Read_Data_2_o = rf.Write_Data_i;
        end else begin
            rf.Read_Data_2_o = regs[rf.Read_Register_2_i];
        end
    end

    assign rf.Onehot_Error_o = onehot_err;
    assign rf.Write_Count_o  = wr_cnt;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. Two instances share the same stimulus:
// dut_b forwards same-cycle writes, dut_n does not.
module tb_register_file;
    localparam logic [31:0] SP = 32'h1001_0FFC;

    logic clk;
    logic reset;
    logic        rw;
    logic [31:0] sel;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;

    int checks = 0;
    int errors = 0;

    register_file_if #(.N(32)) ifb ();
    register_file_if #(.N(32)) ifn ();

    assign ifb.Reg_Write_i = rw;  assign ifn.Reg_Write_i = rw;
    assign ifb.Write_Select_i = sel;  assign ifn.Write_Select_i = sel;
    assign ifb.Write_Data_i = wd;  assign ifn.Write_Data_i = wd;
    assign ifb.Read_Register_1_i = ra1;  assign ifn.Read_Register_1_i = ra1;
    assign ifb.Read_Register_2_i = ra2;  assign ifn.Read_Register_2_i = ra2;

    register_file #(.N(32), .SP_INIT(SP), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .rf(ifb)
    );
    register_file #(.N(32), .SP_INIT(SP), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .rf(ifn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, landing 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic r, input logic [31:0] s, input logic [31:0] d);
        rw = r; sel = s; wd = d;
    endtask

    initial begin
        reset = 1'b0;
        set_wr(1'b0, 32'd0, 32'd0);
        ra1 = 5'd29; ra2 = 5'd5;
        #12;
        // reset state
        check("rst_rd1_sp", ifb.Read_Data_1_o, SP);
        check("rst_rd2_zero", ifb.Read_Data_2_o, 32'd0);
        check("rst_cnt", {16'd0, ifb.Write_Count_o}, 32'd0);
        check("rst_err", {31'd0, ifb.Onehot_Error_o}, 32'd0);
        check("rst_n_rd1_sp", ifn.Read_Data_1_o, SP);
        #1 reset = 1'b1;
        tick();
        check("post_rst_sp", ifb.Read_Data_1_o, SP);

        // basic write to r8, read on both ports
        set_wr(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        tick();
        rw = 1'b0; ra1 = 5'd8; ra2 = 5'd8; #1;
        check("r8_rd1", ifb.Read_Data_1_o, 32'hDEAD_BEEF);
        check("r8_rd2", ifb.Read_Data_2_o, 32'hDEAD_BEEF);
        check("r8_n_rd1", ifn.Read_Data_1_o, 32'hDEAD_BEEF);
        check("r8_cnt", {16'd0, ifb.Write_Count_o}, 32'd1);

        // write to r0: no forward, no store, no count
        set_wr(1'b1, 32'h0000_0001, 32'h1234_5678);
        ra1 = 5'd0; ra2 = 5'd0; #1;
        check("r0_fwd", ifb.Read_Data_1_o, 32'd0);
        tick();
        rw = 1'b0; #1;
        check("r0_rd", ifb.Read_Data_2_o, 32'd0);
        check("r0_cnt", {16'd0, ifb.Write_Count_o}, 32'd1);

        // preload r1, r2
        set_wr(1'b1, 32'h0000_0002, 32'h1111_1111); tick();
        set_wr(1'b1, 32'h0000_0004, 32'h2222_2222); tick();

        // Reg_Write=1, select 0: nothing happens
        set_wr(1'b1, 32'h0000_0000, 32'h5555_5555); tick();
        // Reg_Write=0, multi-bit select: ignored
        set_wr(1'b0, 32'h0000_0006, 32'h6666_6666); tick();
        check("sel0_err", {31'd0, ifb.Onehot_Error_o}, 32'd0);
        check("sel0_cnt", {16'd0, ifb.Write_Count_o}, 32'd3);

        // multi-bit select with Reg_Write=1
        set_wr(1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
        ra1 = 5'd1; ra2 = 5'd2; #1;
        check("multi_nofwd", ifb.Read_Data_1_o, 32'h1111_1111);
        tick();
        rw = 1'b0; #1;
        check("multi_r1", ifb.Read_Data_1_o, 32'h1111_1111);
        check("multi_r2", ifb.Read_Data_2_o, 32'h2222_2222);
        check("multi_err", {31'd0, ifb.Onehot_Error_o}, 32'd1);
        check("multi_cnt", {16'd0, ifb.Write_Count_o}, 32'd3);

        // valid write afterwards keeps the error sticky
        set_wr(1'b1, 32'h0000_0010, 32'h4444_4444); tick();
        rw = 1'b0; ra1 = 5'd4; #1;
        check("sticky_err", {31'd0, ifb.Onehot_Error_o}, 32'd1);
        check("r4_rd", ifb.Read_Data_1_o, 32'h4444_4444);

        // forwarding: write r3 and read r3 in the same cycle
        set_wr(1'b1, 32'h0000_0008, 32'hA5A5_A5A5);
        ra1 = 5'd3; ra2 = 5'd3; #1;
        check("byp_rd1", ifb.Read_Data_1_o, 32'hA5A5_A5A5);
        check("byp_rd2", ifb.Read_Data_2_o, 32'hA5A5_A5A5);
        check("nobyp_rd1", ifn.Read_Data_1_o, 32'd0);
        tick();
        rw = 1'b0; #1;
        check("nobyp_next", ifn.Read_Data_1_o, 32'hA5A5_A5A5);

        // same-data write still counts
        set_wr(1'b1, 32'h0000_0008, 32'hA5A5_A5A5); tick();
        rw = 1'b0; #1;
        check("same_cnt", {16'd0, ifb.Write_Count_o}, 32'd6);

        // fill the counter to saturation through r10
        rw = 1'b1; sel = 32'h0000_0400;
        for (int i = 0; i < 65529; i++) begin
            wd = i;
            tick();
        end
        rw = 1'b0; ra1 = 5'd10; #1;
        check("cnt_full", {16'd0, ifb.Write_Count_o}, 32'h0000_FFFF);
        check("r10_last", ifb.Read_Data_1_o, 32'd65528);
        set_wr(1'b1, 32'h0000_0400, 32'hCAFE_0001); tick();
        rw = 1'b0; #1;
        check("cnt_sat", {16'd0, ifb.Write_Count_o}, 32'h0000_FFFF);
        check("cnt_sat_n", {16'd0, ifn.Write_Count_o}, 32'h0000_FFFF);
        check("r10_sat", ifb.Read_Data_1_o, 32'hCAFE_0001);

        // reset mid-cycle with a write pending
        set_wr(1'b1, 32'h0000_0400, 32'h0000_0077);
        ra1 = 5'd29; ra2 = 5'd10; #1;
        reset = 1'b0; #1;
        check("mid_rst_cnt", {16'd0, ifb.Write_Count_o}, 32'd0);
        check("mid_rst_err", {31'd0, ifb.Onehot_Error_o}, 32'd0);
        check("mid_rst_sp", ifb.Read_Data_1_o, SP);
        check("mid_rst_r10", ifb.Read_Data_2_o, 32'd0);
        tick();
        check("rst_discard", ifb.Read_Data_2_o, 32'd0);
        check("rst_discard_cnt", {16'd0, ifb.Write_Count_o}, 32'd0);
        #2 reset = 1'b1;
        tick();
        rw = 1'b0; #1;
        check("first_wr_r10", ifb.Read_Data_2_o, 32'h0000_0077);
        check("first_wr_cnt", {16'd0, ifb.Write_Count_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
